// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 encodings, the mul/div
// sequencer state encoding and the default register width.
package riscv_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdState_t;

endpackage

// File: rtl/muldiv_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider working on
// operand magnitudes, with sign conversion on the way in and out.
// The corrected result is derived from the post-step accumulator so the
// sequencer can capture it on the same edge as the final iteration.
module muldiv_datapath
    import riscv_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [XLEN-1:0] stepResult
);

    logic [2*XLEN-1:0] accReg;
    logic [2*XLEN-1:0] accNext;
    logic [XLEN-1:0]   opB;
    mdOp_t             opReg;
    logic              negRes;
    logic              negRem;

    mdOp_t             opIn;
    logic              signA;
    logic              signB;
    logic [XLEN-1:0]   magA;
    logic [XLEN-1:0]   magB;

    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divTrial;
    logic [XLEN:0]     divDiff;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   quoFix;
    logic [XLEN-1:0]   remFix;

    // Operand signedness and magnitudes for the incoming op
    always_comb begin
        opIn  = mdOp_t'(funct3);
        signA = (opIn inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & srcA[XLEN-1];
        signB = (opIn inside {OP_MULH, OP_DIV, OP_REM}) & srcB[XLEN-1];
        magA  = signA ? -srcA : srcA;
        magB  = signB ? -srcB : srcB;
    end

    // Single iteration: add-and-shift-right for multiply, shift-and-trial-subtract for divide
    always_comb begin
        mulSum   = {1'b0, accReg[2*XLEN-1:XLEN]} + (accReg[0] ? {1'b0, opB} : '0);
        divTrial = accReg[2*XLEN-1:XLEN-1];
        divDiff  = divTrial - {1'b0, opB};
        if (!opReg[2]) begin
            accNext = {mulSum, accReg[XLEN-1:1]};
        end else if (!divDiff[XLEN]) begin
            accNext = {divDiff[XLEN-1:0], accReg[XLEN-2:0], 1'b1};
        end else begin
            accNext = {divTrial[XLEN-1:0], accReg[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and result word selection
    always_comb begin
        prodFix = negRes ? -accNext : accNext;
        quoFix  = negRes ? -accNext[XLEN-1:0] : accNext[XLEN-1:0];
        remFix  = negRem ? -accNext[2*XLEN-1:XLEN] : accNext[2*XLEN-1:XLEN];
        case (opReg)
            OP_MUL:                       stepResult = prodFix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: stepResult = prodFix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              stepResult = quoFix;
            default:                      stepResult = remFix;
        endcase
    end

    // Operand capture on accept, one iteration per step cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accReg <= '0;
            opB    <= '0;
            opReg  <= OP_MUL;
            negRes <= 1'b0;
            negRem <= 1'b0;
        end else if (load) begin
            accReg <= {{XLEN{1'b0}}, magA};
            opB    <= magB;
            opReg  <= opIn;
            negRes <= signA ^ signB;
            negRem <= signA;
        end else if (step) begin
            accReg <= accNext;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide controller for the execute stage.
// Stalls the front of the pipeline while busy and presents the result
// with a single-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for an M-op; stall follows start
//   RUN   | iterating, one bit per cycle, XLEN cycles
//   DONE  | result valid for one cycle, then back to IDLE
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    mdState_t         state;
    mdState_t         stateNext;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             stepEn;
    logic             lastIter;
    logic             divZero;
    logic             divOvf;
    logic             special;
    logic [XLEN-1:0]  specialVal;
    logic [XLEN-1:0]  dpResult;
    logic [XLEN-1:0]  resultReg;

    muldiv_datapath #(.XLEN(XLEN)) uDatapath (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .step       (stepEn),
        .funct3     (funct3),
        .srcA       (src_a),
        .srcB       (src_b),
        .stepResult (dpResult)
    );

    // Divide-by-zero and signed overflow bypass the iterative datapath
    always_comb begin
        divZero = funct3[2] & (src_b == '0);
        divOvf  = (mdOp_t'(funct3) inside {OP_DIV, OP_REM})
                  & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (src_b == '1);
        special = divZero | divOvf;
        if (divZero) begin
            specialVal = funct3[1] ? src_a : '1;
        end else begin
            specialVal = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        lastIter = (cnt == CNT_W'(XLEN-1));
    end

    // Next-state and control decode
    always_comb begin
        stateNext = state;
        stall_o   = 1'b0;
        accept    = 1'b0;
        stepEn    = 1'b0;
        case (state)
            IDLE: begin
                stall_o = start;
                if (start && !flush) begin
                    accept    = 1'b1;
                    stateNext = special ? DONE : RUN;
                end
            end
            RUN: begin
                stall_o = 1'b1;
                if (flush) begin
                    stateNext = IDLE;
                end else begin
                    stepEn = 1'b1;
                    if (lastIter) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register and iteration counter (counter is zero outside RUN)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= (state == RUN && stateNext == RUN) ? cnt + 1'b1 : '0;
        end
    end

    // Result is captured only on entry to DONE and held until the next op completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultReg <= '0;
        end else if (accept && special) begin
            resultReg <= specialVal;
        end else if (stepEn && lastIter) begin
            resultReg <= dpResult;
        end
    end

    assign done_o   = (state == DONE);
    assign result_o = resultReg;

endmodule
